// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced, edge-detected 4-button press reporter
//
// Purpose : Synchronizes four raw push-button levels, debounces a press,
//           reports exactly one press per hold and waits for a debounced
//           release before arming again.
// Ports   : clk          - sole clock, rising edge
//           rst          - synchronous active-high reset
//           btn[3:0]     - raw asynchronous button levels, bit i = colour i
//           enable       - high while the game is awaiting player input
//           press_valid  - one-cycle pulse per accepted press
//           press_code   - index of the pressed button (valid with press_valid)
//           press_onehot - one-hot of press_code during press_valid, else 0
//           busy         - high whenever the FSM is not IDLE
//           multi_err    - one-cycle pulse when a multi-button press is rejected
// Config  : BTN_MULTI_REJECT_EN - when defined, a confirmed multi-button
//           capture raises multi_err instead of reporting the lowest button.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       enable,
  output logic       press_valid,
  output logic [1:0] press_code,
  output logic [3:0] press_onehot,
  output logic       busy,
  output logic       multi_err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESS    = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  localparam logic [23:0] C_TERM = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] C_MAX  = 24'hFF_FFFF;

  logic [3:0]  r_sync1;
  logic [3:0]  r_s;
  state_t      r_state;
  logic [3:0]  r_cap;
  logic [23:0] r_cnt;
  logic        r_press_valid;
  logic [1:0]  r_press_code;
  logic [3:0]  r_press_onehot;
  logic        r_busy;
  logic        r_multi_err;

  state_t      w_state_nx;
  logic [3:0]  w_cap_nx;
  logic [23:0] w_cnt_nx;
  logic [23:0] w_cnt_inc;
  logic        w_pv_nx;
  logic [1:0]  w_code_nx;
  logic [3:0]  w_onehot_nx;
  logic        w_merr_nx;
  logic [3:0]  w_low_onehot;
  logic [1:0]  w_low_idx;
  logic        w_reject;

  // Saturating increment: the counter must never wrap back to zero.
  assign w_cnt_inc = (r_cnt == C_MAX) ? r_cnt : r_cnt + 24'd1;

  // Isolate the lowest set bit of the capture (two's-complement trick).
  assign w_low_onehot = r_cap & (~r_cap + 4'd1);

  always_comb begin
    w_low_idx = 2'd0;
    if (r_cap[0])      w_low_idx = 2'd0;
    else if (r_cap[1]) w_low_idx = 2'd1;
    else if (r_cap[2]) w_low_idx = 2'd2;
    else if (r_cap[3]) w_low_idx = 2'd3;
  end

`ifdef BTN_MULTI_REJECT_EN
  assign w_reject = (r_cap & (r_cap - 4'd1)) != 4'd0;
`else
  assign w_reject = 1'b0;
`endif

  always_comb begin
    w_state_nx  = r_state;
    w_cap_nx    = r_cap;
    w_cnt_nx    = r_cnt;
    w_pv_nx     = 1'b0;
    w_code_nx   = 2'd0;
    w_onehot_nx = 4'd0;
    w_merr_nx   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && (r_s != 4'd0)) begin
          w_cap_nx   = r_s;
          w_cnt_nx   = 24'd0;
          w_state_nx = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (!enable) begin
          w_cnt_nx   = 24'd0;
          w_state_nx = S_RELEASE;
        end else if (r_s == r_cap) begin
          if (r_cnt >= C_TERM) begin
            w_cnt_nx = 24'd0;
            if (w_reject) begin
              w_merr_nx  = 1'b1;
              w_state_nx = S_RELEASE;
            end else begin
              // Outputs are registered on the entry edge so the pulse
              // coincides with the single PRESS cycle.
              w_pv_nx     = 1'b1;
              w_code_nx   = w_low_idx;
              w_onehot_nx = w_low_onehot;
              w_state_nx  = S_PRESS;
            end
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end else if (r_s == 4'd0) begin
          w_state_nx = S_IDLE;
        end else begin
          w_cap_nx = r_s;
          w_cnt_nx = 24'd0;
        end
      end
      S_PRESS: begin
        w_cnt_nx   = 24'd0;
        w_state_nx = S_RELEASE;
      end
      S_RELEASE: begin
        if (r_s != 4'd0) begin
          w_cnt_nx = 24'd0;
        end else if (r_cnt >= C_TERM) begin
          w_cnt_nx   = 24'd0;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      default: begin
        w_cnt_nx   = 24'd0;
        w_state_nx = S_RELEASE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1        <= 4'd0;
      r_s            <= 4'd0;
      r_state        <= S_RELEASE;
      r_cap          <= 4'd0;
      r_cnt          <= 24'd0;
      r_press_valid  <= 1'b0;
      r_press_code   <= 2'd0;
      r_press_onehot <= 4'd0;
      r_busy         <= 1'b1;
      r_multi_err    <= 1'b0;
    end else begin
      r_sync1        <= btn;
      r_s            <= r_sync1;
      r_state        <= w_state_nx;
      r_cap          <= w_cap_nx;
      r_cnt          <= w_cnt_nx;
      r_press_valid  <= w_pv_nx;
      r_press_code   <= w_code_nx;
      r_press_onehot <= w_onehot_nx;
      r_busy         <= (w_state_nx != S_IDLE);
      r_multi_err    <= w_merr_nx;
    end
  end

  assign press_valid  = r_press_valid;
  assign press_code   = r_press_code;
  assign press_onehot = r_press_onehot;
  assign busy         = r_busy;
  assign multi_err    = r_multi_err;

endmodule
